// File: rtl/slot_i2s_tx_pkg.sv
// Shared constants, state type and slot helper for the I2S slot transmitter.
package slot_i2s_tx_pkg;

  localparam int I2S_SLOT_BITS  = 32;
  localparam int I2S_FRAME_BITS = 64;
  localparam int I2S_SLOT_W     = $clog2(I2S_SLOT_BITS);
  localparam int I2S_POS_W      = $clog2(I2S_FRAME_BITS);

  typedef enum logic {I2S_IDLE, I2S_RUN} i2s_state_t;

  // Slot 0 is the one-bit I2S delay; slots 1..width carry the sample MSB first.
  function automatic logic slot_carries_data(input logic [I2S_SLOT_W-1:0] slot,
                                             input int width);
    return (slot != '0) && (int'(slot) <= width);
  endfunction

endpackage

// File: rtl/slot_i2s_tx_bit_clock.sv
// Bit-clock generator: bck divider, 64-position frame counter and RUN/IDLE control.
module slot_i2s_tx_bit_clock
  import slot_i2s_tx_pkg::*;
#(
  parameter int BCK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 bck,
  output logic                 fall_strobe,
  output logic                 frame_start,
  output logic [I2S_POS_W-1:0] position
);

  localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [I2S_POS_W-1:0] POS_LAST = I2S_POS_W'(I2S_FRAME_BITS - 1);

  i2s_state_t       state, state_next;
  logic [DIV_W-1:0] div_cnt;
  logic             tc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= I2S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = enable ? I2S_RUN : I2S_IDLE;
  end

  // The IDLE->RUN edge is itself a frame start, so position 0 appears with bck still low.
  always_comb begin
    tc          = (state == I2S_RUN) && (div_cnt == DIV_LAST);
    fall_strobe = tc && bck;
    frame_start = ((state == I2S_IDLE) && enable) ||
                  (fall_strobe && (position == POS_LAST));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      bck      <= 1'b0;
      position <= '0;
    end else if (state != I2S_RUN || state_next != I2S_RUN) begin
      div_cnt  <= '0;
      bck      <= 1'b0;
      position <= '0;
    end else if (tc) begin
      div_cnt <= '0;
      bck     <= ~bck;
      if (bck) position <= position + I2S_POS_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/slot_i2s_tx.sv
// I2S transmitter for a DAC-mode slot: one-frame holding register, per-line shifters, underrun tracking.
module slot_i2s_tx
  import slot_i2s_tx_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int NUM_LINES    = 4,
  parameter int BCK_DIV      = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [2*NUM_LINES*SAMPLE_WIDTH-1:0]   in_data,
  output logic                                  bck,
  output logic                                  lrck,
  output logic [NUM_LINES-1:0]                  sdata,
  output logic                                  underrun,
  output logic [15:0]                           underrun_count
);

  localparam int FRAME_W = 2 * NUM_LINES * SAMPLE_WIDTH;

  logic                                      fall_strobe;
  logic                                      frame_start;
  logic [I2S_POS_W-1:0]                      position;
  logic [I2S_POS_W-1:0]                      pos_next;
  logic                                      right_half;
  logic                                      data_slot;
  logic                                      hold_valid;
  logic                                      xfer;
  logic [FRAME_W-1:0]                        hold_data;
  logic [NUM_LINES-1:0][SAMPLE_WIDTH-1:0]    shift_l;
  logic [NUM_LINES-1:0][SAMPLE_WIDTH-1:0]    shift_r;
  logic [15:0]                               ur_count;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  slot_i2s_tx_bit_clock #(
    .BCK_DIV(BCK_DIV)
  ) u_bit_clock (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .bck        (bck),
    .fall_strobe(fall_strobe),
    .frame_start(frame_start),
    .position   (position)
  );

  assign in_ready       = !hold_valid;
  assign xfer           = in_valid && !hold_valid;
  assign pos_next       = position + I2S_POS_W'(1);
  assign right_half     = pos_next[I2S_POS_W-1];
  assign data_slot      = slot_carries_data(pos_next[I2S_SLOT_W-1:0], SAMPLE_WIDTH);
  assign underrun_count = ur_count;

  // xfer implies the register was empty, so it never collides with a consuming frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            hold_valid <= 1'b0;
    else if (xfer)        hold_valid <= 1'b1;
    else if (frame_start) hold_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (xfer) hold_data <= in_data;
  end

  // Shifters feed their MSB to sdata on each data-slot falling edge; empty hold loads silence.
  always_ff @(posedge clk) begin
    if (frame_start) begin
      for (int k = 0; k < NUM_LINES; k++) begin
        shift_l[k] <= hold_valid ? hold_data[(2*k)*SAMPLE_WIDTH +: SAMPLE_WIDTH] : '0;
        shift_r[k] <= hold_valid ? hold_data[(2*k+1)*SAMPLE_WIDTH +: SAMPLE_WIDTH] : '0;
      end
    end else if (fall_strobe && data_slot) begin
      for (int k = 0; k < NUM_LINES; k++) begin
        if (right_half) shift_r[k] <= shift_r[k] << 1;
        else            shift_l[k] <= shift_l[k] << 1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lrck     <= 1'b0;
      sdata    <= '0;
      underrun <= 1'b0;
      ur_count <= '0;
    end else begin
      underrun <= frame_start && !hold_valid;
      if (frame_start && !hold_valid) ur_count <= sat_inc(ur_count);
      if (!enable || frame_start) begin
        lrck  <= 1'b0;
        sdata <= '0;
      end else if (fall_strobe) begin
        lrck <= right_half;
        for (int k = 0; k < NUM_LINES; k++) begin
          sdata[k] <= data_slot &&
                      (right_half ? shift_r[k][SAMPLE_WIDTH-1] : shift_l[k][SAMPLE_WIDTH-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_slot_i2s_tx.sv
// Bench for slot_i2s_tx: random frames decoded by a slot receiver model and compared with the source order.
module tb_slot_i2s_tx;

  localparam int SW        = 24;
  localparam int NL        = 4;
  localparam int BD        = 4;
  localparam int FW        = 2 * NL * SW;
  localparam int BIT_CYC   = 2 * BD;
  localparam int FRAME_CYC = 64 * BIT_CYC;

  typedef logic [FW-1:0] frame_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_data;
  logic          bck;
  logic          lrck;
  logic [NL-1:0] sdata;
  logic          underrun;
  logic [15:0]   underrun_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int e0      = 0;
  int run_id  = 0;
  logic mon_on = 1'b0;

  frame_t to_send[$];
  frame_t exp_q[$];
  frame_t rx_q[$];

  slot_i2s_tx #(
    .SAMPLE_WIDTH(SW),
    .NUM_LINES   (NL),
    .BCK_DIV     (BD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .bck           (bck),
    .lrck          (lrck),
    .sdata         (sdata),
    .underrun      (underrun),
    .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int c = 0; c < 2 * NL; c++) f[c*SW +: SW] = SW'($urandom);
    return f;
  endfunction

  // Source: presents queued frames one at a time, honouring the valid/ready handshake.
  initial begin
    logic hs;
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(posedge clk);
      hs = in_valid && in_ready;
      @(negedge clk);
      if (hs) in_valid = 1'b0;
      if (!in_valid && to_send.size() > 0) begin
        in_data  = to_send.pop_front();
        in_valid = 1'b1;
      end
    end
  end

  // Slot receiver model: samples on bck rising edges, realigns on lrck changes, rebuilds frames.
  int     seen_id = 0;
  int     last_rise, last_lr, idx, pad_err, ur_seen;
  logic   pbck = 1'b0, plrck = 1'b0, m_lrck;
  logic [SW-1:0] wl [NL];
  logic [SW-1:0] wr [NL];
  frame_t mf;

  initial begin
    forever begin
      @(negedge clk);
      if (seen_id != run_id) begin
        seen_id   = run_id;
        last_rise = e0 - BD;
        last_lr   = e0;
        m_lrck    = 1'b1;
        idx       = 0;
        pad_err   = 0;
        ur_seen   = 0;
        rx_q.delete();
      end
      if (mon_on) begin
        if (lrck !== plrck) begin
          check("lrck_period", cyc - last_lr, FRAME_CYC / 2);
          last_lr = cyc;
        end
        if (bck && !pbck) begin
          check("bck_period", cyc - last_rise, BIT_CYC);
          last_rise = cyc;
          if (lrck !== m_lrck) idx = 0;
          else                 idx++;
          m_lrck = lrck;
          for (int k = 0; k < NL; k++) begin
            if (idx >= 1 && idx <= SW) begin
              if (lrck) wr[k] = {wr[k][SW-2:0], sdata[k]};
              else      wl[k] = {wl[k][SW-2:0], sdata[k]};
            end else if (sdata[k] !== 1'b0) begin
              pad_err++;
            end
          end
          if (lrck && idx == 31) begin
            for (int k = 0; k < NL; k++) begin
              mf[(2*k)*SW +: SW]   = wl[k];
              mf[(2*k+1)*SW +: SW] = wr[k];
            end
            rx_q.push_back(mf);
          end
        end
        if (underrun) begin
          check("underrun_phase", (cyc - e0) % FRAME_CYC, 0);
          ur_seen++;
        end
      end
      pbck  = bck;
      plrck = lrck;
    end
  end

  task automatic start_run();
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
    e0     = cyc;
    run_id = run_id + 1;
    mon_on = 1'b1;
  endtask

  task automatic stop_run();
    @(negedge clk);
    mon_on = 1'b0;
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_rx(input string tag, input int n);
    frame_t a, b;
    check({tag, "_frames"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size() && i < exp_q.size(); i++) begin
      a = rx_q[i];
      b = exp_q[i];
      for (int c = 0; c < 2 * NL; c++)
        check($sformatf("%s_f%0d_ch%0d", tag, i, c), a[c*SW +: SW], b[c*SW +: SW]);
    end
  endtask

  initial begin
    frame_t f, g;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bck", bck, 0);
    check("rst_lrck", lrck, 0);
    check("rst_sdata", sdata, 0);
    check("rst_underrun", underrun, 0);
    check("rst_count", underrun_count, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Single frame on line 0, then silence.
    f = rand_frame();
    f[0 +: SW]  = 24'h800001;
    f[SW +: SW] = 24'h7FFFFE;
    exp_q.delete();
    exp_q.push_back(f);
    exp_q.push_back('0);
    to_send.push_back(f);
    repeat (3) @(negedge clk);
    check("single_hold_full", in_ready, 0);
    start_run();
    @(negedge clk);
    check("single_start_bck", bck, 0);
    check("single_start_lrck", lrck, 0);
    check("single_start_underrun", underrun, 0);
    check("single_start_ready", in_ready, 1);
    wait_until(e0 + 2 * FRAME_CYC + 8);
    check_rx("single", 2);
    check("single_ur_count", underrun_count, 2);
    check("single_ur_seen", ur_seen, 2);
    check("single_pad", pad_err, 0);
    stop_run();

    // Eight channels streamed continuously.
    pulse_reset();
    exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      if (i == 0) for (int c = 0; c < 2 * NL; c++) f[c*SW +: SW] = SW'(32'h100000 * c + c);
      else        f = rand_frame();
      exp_q.push_back(f);
      to_send.push_back(f);
    end
    repeat (3) @(negedge clk);
    start_run();
    wait_until(e0 + 16 * FRAME_CYC + 8);
    check_rx("stream", 16);
    check("stream_ur_count", underrun_count, 0);
    check("stream_ur_seen", ur_seen, 0);
    check("stream_pad", pad_err, 0);
    stop_run();

    // Enable dropped at position 40 with a second frame held.
    f = rand_frame();
    g = rand_frame();
    to_send.push_back(f);
    to_send.push_back(g);
    repeat (3) @(negedge clk);
    start_run();
    wait_until(e0 + 40 * BIT_CYC + 2);
    check("drop_lrck_before", lrck, 1);
    mon_on = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("drop_bck", bck, 0);
    check("drop_lrck", lrck, 0);
    check("drop_sdata", sdata, 0);
    check("drop_hold_kept", in_ready, 0);
    repeat (20) @(negedge clk);
    exp_q.delete();
    exp_q.push_back(g);
    start_run();
    @(negedge clk);
    check("reen_lrck", lrck, 0);
    check("reen_underrun", underrun, 0);
    wait_until(e0 + FRAME_CYC + 8);
    check_rx("reen", 1);
    check("reen_ur_count", underrun_count, 1);
    stop_run();

    // Underrun with no input, then saturation.
    pulse_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back('0);
    start_run();
    wait_until(e0 + 4 * FRAME_CYC + 8);
    check_rx("underrun", 4);
    check("underrun_seen", ur_seen, 5);
    check("underrun_count", underrun_count, 5);
    check("underrun_pad", pad_err, 0);
    check("underrun_sdata", sdata, 0);
    force dut.ur_count = 16'hFFFD;
    @(negedge clk);
    release dut.ur_count;
    wait_until(e0 + 6 * FRAME_CYC + 8);
    check("sat_reach", underrun_count, 16'hFFFF);
    wait_until(e0 + 8 * FRAME_CYC + 8);
    check("sat_hold", underrun_count, 16'hFFFF);
    check("sat_seen", ur_seen, 9);

    // Asynchronous reset in the middle of a word.
    to_send.push_back(rand_frame());
    wait_until(e0 + 8 * FRAME_CYC + 37 * BIT_CYC + BD);
    check("arst_pre_lrck", lrck, 1);
    check("arst_pre_bck", bck, 1);
    check("arst_pre_ready", in_ready, 0);
    #3;
    mon_on = 1'b0;
    reset  = 1'b1;
    #1;
    check("arst_bck", bck, 0);
    check("arst_lrck", lrck, 0);
    check("arst_sdata", sdata, 0);
    check("arst_underrun", underrun, 0);
    check("arst_count", underrun_count, 0);
    check("arst_ready", in_ready, 1);
    enable = 1'b0;
    #7;
    reset = 1'b0;
    @(negedge clk);
    check("arst_ready_after", in_ready, 1);
    check("arst_bck_after", bck, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
